demorgan_checker: RTL

- Hardware response checker: the consuming end of the De Morgan truth-table interface.
- Sequences A/B through all four input vectors into a demorgan DUT and waits a programmable settle time.
- Samples the eight DUT outputs, compares them against internally computed expected values, and reports pass/fail, error count and the first failing vector.
- Replaces manual inspection of the printed truth table with a self-checking block usable in simulation or on a board.

---
 rtl/demorgan_checker_if.sv | 29 ++
 rtl/demorgan_checker.sv | 111 +++++++++++
 2 files changed

// File: rtl/demorgan_checker_if.sv
// Bus between the De Morgan response checker and its environment:
// stimulus/observation lines towards the DUT plus run control and results.
interface demorgan_checker_if #(
  parameter int ERR_W = 4
);
  logic             start;
  logic             a_out;
  logic             b_out;
  logic [7:0]       obs;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [1:0]       first_fail_vec;
  logic [7:0]       first_fail_mask;

  modport master (
    input  start, obs,
    output a_out, b_out, busy, done, pass, err_count,
           fail_valid, first_fail_vec, first_fail_mask
  );

  modport slave (
    output start, obs,
    input  a_out, b_out, busy, done, pass, err_count,
           fail_valid, first_fail_vec, first_fail_mask
  );
endinterface

// File: rtl/demorgan_checker.sv
// Self-checking driver for a De Morgan truth-table DUT: walks {A,B} through
// 00..11, lets each vector settle, samples the eight outputs and scores them.
module demorgan_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input logic                clk,
  input logic                reset,
  demorgan_checker_if.master bus
);
  localparam int SETTLE = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t           state;
  logic [1:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       exp_obs;
  logic [7:0]       diff;
  logic             mismatch;

  // Case-inequality so that X/Z on the observed lines is scored as a failure.
  always_comb begin
    exp_obs[0] = ~vec[1];
    exp_obs[1] = ~vec[0];
    exp_obs[2] = vec[1] | vec[0];
    exp_obs[3] = vec[1] & vec[0];
    exp_obs[4] = ~vec[1] & ~vec[0];
    exp_obs[5] = ~(vec[1] | vec[0]);
    exp_obs[6] = ~(vec[1] & vec[0]);
    exp_obs[7] = ~vec[1] | ~vec[0];
    diff       = bus.obs ^ exp_obs;
    mismatch   = (bus.obs !== exp_obs);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      vec                 <= '0;
      cnt                 <= '0;
      bus.a_out           <= 1'b0;
      bus.b_out           <= 1'b0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.pass            <= 1'b0;
      bus.err_count       <= '0;
      bus.fail_valid      <= 1'b0;
      bus.first_fail_vec  <= '0;
      bus.first_fail_mask <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state               <= DRIVE;
            vec                 <= '0;
            cnt                 <= '0;
            bus.a_out           <= 1'b0;
            bus.b_out           <= 1'b0;
            bus.busy            <= 1'b1;
            bus.done            <= 1'b0;
            bus.pass            <= 1'b0;
            bus.err_count       <= '0;
            bus.fail_valid      <= 1'b0;
            bus.first_fail_vec  <= '0;
            bus.first_fail_mask <= '0;
          end
        end

        DRIVE: begin
          if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SAMPLE: begin
          if (mismatch) begin
            if (bus.err_count != ERR_MAX) begin
              bus.err_count <= bus.err_count + ERR_W'(1);
            end
            if (!bus.fail_valid) begin
              bus.fail_valid      <= 1'b1;
              bus.first_fail_vec  <= vec;
              bus.first_fail_mask <= diff;
            end
          end
          // Pass must reflect this last sample too, since err_count updates on the same edge.
          if (vec == 2'd3) begin
            state     <= DONE;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            bus.pass  <= (bus.err_count == '0) && !mismatch;
            bus.a_out <= 1'b0;
            bus.b_out <= 1'b0;
          end else begin
            state                  <= DRIVE;
            vec                    <= vec + 2'd1;
            cnt                    <= '0;
            {bus.a_out, bus.b_out} <= vec + 2'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
